// File: rtl/fir13_pkg.sv
// rtl/fir13_pkg.sv - shared types and constants for the fir13 stream controller
//
// Contents:
//   FIR13_TAPS       filter tap count (13)
//   FIR13_SAMPLE_W   sample width (8, two's complement)
//   fir13_state_e    controller states IDLE / RUN / FLUSH
//   fir13_tag_t      {valid, last} tag that travels alongside each filter input
package fir13_pkg;

    localparam int FIR13_TAPS     = 13;
    localparam int FIR13_SAMPLE_W = 8;

    typedef enum logic [1:0] {
        FIR13_IDLE  = 2'd0,
        FIR13_RUN   = 2'd1,
        FIR13_FLUSH = 2'd2
    } fir13_state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } fir13_tag_t;

endpackage

// File: rtl/fir13_tag_delay.sv
// rtl/fir13_tag_delay.sv - LAT-stage shift register for the {valid, last} tag
//
// Parameters:
//   LAT      number of register stages (>= 1)
// Ports:
//   clk      rising-edge clock
//   n_rst    asynchronous active-low reset, clears every stage
//   tag_in   tag entering the pipeline
//   tag_out  tag after LAT edges
module fir13_tag_delay
    import fir13_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  fir13_tag_t tag_in,
    output fir13_tag_t tag_out
);

    fir13_tag_t stage_d [LAT];
    fir13_tag_t stage_q [LAT];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/fir13_stream_ctrl.sv
// rtl/fir13_stream_ctrl.sv - frame sequencer feeding a free-running 13-tap FIR
//
// Drives the filter input every cycle: frame samples while a frame is
// active, zeros when idle, and TAPS-1 zero flush samples after each frame.
// A {valid, last} tag follows each filter input through FIR_LAT stages so
// m_valid/m_last line up with the filter output.
//
// Optional feature macro: FIR13_CTRL_UNDERRUN_ERR_EN
//   defined     err is a sticky flag set by any RUN-state underrun cycle,
//               cleared by err_clr (a simultaneous underrun wins)
//   undefined   err is held at 0 and err_clr is ignored
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   s_valid/s_ready     input sample handshake
//   s_data, s_last      signed sample, end-of-frame marker
//   fir_x               registered drive to the filter x_in
//   fir_y               filter y_out
//   m_valid, m_last     output sample / final output of frame (incl. tail)
//   m_data              fir_y pass-through
//   m_count             outputs emitted so far in the current frame
//   busy                controller not idle
//   err, err_clr        sticky underrun flag and its clear
module fir13_stream_ctrl
    import fir13_pkg::*;
#(
    parameter int TAPS    = FIR13_TAPS,
    parameter int FIR_LAT = 1,
    parameter int CNT_W   = 12
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic signed [FIR13_SAMPLE_W-1:0] s_data,
    input  logic                             s_last,
    output logic signed [FIR13_SAMPLE_W-1:0] fir_x,
    input  logic signed [FIR13_SAMPLE_W-1:0] fir_y,
    output logic                             m_valid,
    output logic signed [FIR13_SAMPLE_W-1:0] m_data,
    output logic                             m_last,
    output logic [CNT_W-1:0]                 m_count,
    output logic                             busy,
    output logic                             err,
    input  logic                             err_clr
);

    localparam int FCW = $clog2(TAPS);

    localparam logic [1:0] ST_IDLE  = FIR13_IDLE;
    localparam logic [1:0] ST_RUN   = FIR13_RUN;
    localparam logic [1:0] ST_FLUSH = FIR13_FLUSH;

    logic [1:0]                       state_q,     state_d;
    logic [FCW-1:0]                   flush_cnt_q, flush_cnt_d;
    logic signed [FIR13_SAMPLE_W-1:0] fir_x_q,     fir_x_d;
    fir13_tag_t                       tag_q,       tag_d;
    logic [CNT_W-1:0]                 m_count_q,   m_count_d;
    logic                             err_q,       err_d;

    fir13_tag_t tag_out;
    logic       accept;
    logic       underrun;

    // Gated by n_rst so nothing is accepted while reset is held.
    assign s_ready = n_rst && (state_q != ST_FLUSH);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        fir_x_d     = '0;
        tag_d       = '0;
        underrun    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    fir_x_d     = s_data;
                    tag_d.valid = 1'b1;
                    if (s_last) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FCW'(TAPS - 1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Every RUN cycle is a frame sample; a missing input becomes zero.
                tag_d.valid = 1'b1;
                if (accept) begin
                    fir_x_d = s_data;
                    if (s_last) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FCW'(TAPS - 1);
                    end
                end else begin
                    underrun = 1'b1;
                end
            end
            ST_FLUSH: begin
                tag_d.valid = 1'b1;
                flush_cnt_d = flush_cnt_q - FCW'(1);
                if (flush_cnt_q == FCW'(1)) begin
                    tag_d.last = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m_count_d = m_count_q;
        if (tag_out.valid && tag_out.last) begin
            m_count_d = '0;
        end else if (tag_out.valid) begin
            m_count_d = m_count_q + CNT_W'(1);
        end
    end

`ifdef FIR13_CTRL_UNDERRUN_ERR_EN
    always_comb begin
        err_d = err_q;
        if (underrun) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end
`else
    logic unused_err_inputs;
    assign unused_err_inputs = err_clr ^ underrun;

    always_comb begin
        err_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            fir_x_q     <= '0;
            tag_q       <= '0;
            m_count_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            fir_x_q     <= fir_x_d;
            tag_q       <= tag_d;
            m_count_q   <= m_count_d;
            err_q       <= err_d;
        end
    end

    fir13_tag_delay #(
        .LAT (FIR_LAT)
    ) u_tag_delay (
        .clk     (clk),
        .n_rst   (n_rst),
        .tag_in  (tag_q),
        .tag_out (tag_out)
    );

    assign fir_x   = fir_x_q;
    assign m_valid = tag_out.valid;
    assign m_last  = tag_out.last;
    assign m_data  = fir_y;
    assign m_count = m_count_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_fir13_stream_ctrl.sv
// tb/tb_fir13_stream_ctrl.sv - self-checking bench for fir13_stream_ctrl
module tb_fir13_stream_ctrl;

    localparam int GAP = 999;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              s_valid;
    logic              s_ready;
    logic signed [7:0] s_data;
    logic              s_last;
    logic signed [7:0] fir_x;
    logic        [7:0] fir_y = '0;
    logic              m_valid;
    logic        [7:0] m_data;
    logic              m_last;
    logic       [11:0] m_count;
    logic              busy;
    logic              err;
    logic              err_clr;

    always #5 clk = ~clk;

    fir13_stream_ctrl #(
        .TAPS    (13),
        .FIR_LAT (1),
        .CNT_W   (12)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .fir_x   (fir_x),
        .fir_y   (fir_y),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_count (m_count),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    int coef [13] = '{3, -1, 4, 1, -5, 9, 2, -6, 5, 3, -5, 8, 9};

    // Stand-in for the filter: samples fir_x every edge, one edge of latency.
    int hist [13] = '{default: 0};
    always @(posedge clk) begin : env_filter
        int acc;
        for (int j = 12; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = int'(fir_x);
        acc = 0;
        for (int j = 0; j < 13; j++) acc += coef[j] * hist[j];
        fir_y <= 8'(acc);
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cnt;
    } exp_t;

    exp_t       exp_q [$];
    int         stim_q [$];
    logic [7:0] cap_data [$];
    logic       cap_last [$];
    int         cap_cnt [$];
    logic [7:0] ref_data [$];
    logic       cap_en = 1'b0;
    logic       in_frame = 1'b0;
    logic       saw_wrap = 1'b0;
    int         mv_cnt = 0;
    int         first_wait = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected output of one frame: full convolution of the frame samples
    // (underrun gaps as zeros) plus 12 flush zeros, from a clean delay line.
    task automatic model_frame();
        int   x [$];
        int   acc;
        exp_t e;
        foreach (stim_q[i]) x.push_back(stim_q[i] == GAP ? 0 : stim_q[i]);
        repeat (12) x.push_back(0);
        for (int n = 0; n < x.size(); n++) begin
            acc = 0;
            for (int k = 0; k < 13; k++) begin
                if (n - k >= 0) acc += coef[k] * x[n-k];
            end
            e.data = 8'(acc);
            e.last = (n == x.size() - 1);
            e.cnt  = n % 4096;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_frame();
        int w;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (stim_q[i] == GAP) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk); #1;
            end else begin
                s_valid = 1'b1;
                s_data  = 8'(stim_q[i]);
                s_last  = (i == stim_q.size() - 1);
                w = 0;
                while (!s_ready && w < 100) begin
                    @(posedge clk); #1;
                    w++;
                end
                if (i == 0) first_wait = w;
                if (w >= 100) check("s_ready_timeout", w, 0);
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame();
        model_frame();
        drive_frame();
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 6000) begin
            @(posedge clk);
            w++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cap_clear();
        cap_data.delete();
        cap_last.delete();
        cap_cnt.delete();
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (n_rst) begin
            if (in_frame) check("m_valid_contiguous", int'(m_valid), 1);
            if (m_valid) begin
                mv_cnt++;
                if (in_frame && m_count == 12'd0) saw_wrap = 1'b1;
                if (cap_en) begin
                    cap_data.push_back(m_data);
                    cap_last.push_back(m_last);
                    cap_cnt.push_back(int'(m_count));
                end
                check("expected_output_pending", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_data", int'(m_data), int'(e.data));
                    check("m_last", int'(m_last), int'(e.last));
                    check("m_count", int'(m_count), e.cnt);
                end
                in_frame = !m_last;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int imp_lit [13] = '{3, 255, 4, 1, 251, 9, 2, 250, 5, 3, 251, 8, 9};
    int w;

    initial begin
        n_rst   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        err_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_fir_x", int'(fir_x), 0);
        check("rst_m_count", int'(m_count), 0);
        n_rst = 1'b1;
        #1;
        check("idle_s_ready", int'(s_ready), 1);
        @(posedge clk); #1;

        // Impulse: 1 then 21 zeros -> 22 + 12 = 34 outputs
        stim_q.delete();
        stim_q.push_back(1);
        repeat (21) stim_q.push_back(0);
        cap_clear();
        cap_en = 1'b1;
        run_frame();
        wait_drain();
        cap_en = 1'b0;
        check("impulse_len", cap_data.size(), 34);
        if (cap_data.size() == 34) begin
            for (int i = 0; i < 13; i++) check("impulse_coef", int'(cap_data[i]), imp_lit[i]);
            check("impulse_out14", int'(cap_data[13]), 0);
            check("impulse_last", int'(cap_last[33]), 1);
            check("impulse_not_last", int'(cap_last[32]), 0);
            check("impulse_count_at_last", cap_cnt[33], 33);
        end
        check("impulse_count_after", int'(m_count), 0);

        // Single-sample frame from IDLE
        stim_q.delete();
        stim_q.push_back(-128);
        cap_clear();
        cap_en = 1'b1;
        run_frame();
        check("single_busy", int'(busy), 1);
        w = 0;
        while (!s_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("single_ready_low_cycles", w, 12);
        wait_drain();
        cap_en = 1'b0;
        check("single_len", cap_data.size(), 13);
        if (cap_data.size() == 13) begin
            check("single_out0", int'(cap_data[0]), 128);
            check("single_out2", int'(cap_data[2]), 0);
            check("single_out12", int'(cap_data[12]), 128);
        end

        // Underrun: 10 samples with a 2-cycle gap in RUN
        stim_q.delete();
        for (int i = 1; i <= 4; i++) stim_q.push_back(i * 11);
        stim_q.push_back(GAP);
        stim_q.push_back(GAP);
        for (int i = 5; i <= 10; i++) stim_q.push_back(-i * 7);
        cap_clear();
        cap_en = 1'b1;
        run_frame();
        wait_drain();
        cap_en = 1'b0;
        check("underrun_len", cap_data.size(), 24);
`ifdef FIR13_CTRL_UNDERRUN_ERR_EN
        check("underrun_err", int'(err), 1);
`else
        check("underrun_err", int'(err), 0);
`endif
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_cleared", int'(err), 0);

        // Back-to-back frames
        cap_clear();
        cap_en = 1'b1;
        stim_q = '{5, -7, 12, 100, -100, 33, -1, 64};
        run_frame();
        stim_q = '{-3, 17, -90, 45, 8, -128, 127, 2};
        run_frame();
        check("b2b_gap", first_wait, 12);
        wait_drain();
        cap_en = 1'b0;
        check("b2b_len", cap_data.size(), 40);
        ref_data.delete();
        if (cap_data.size() == 40) begin
            for (int i = 20; i < 40; i++) ref_data.push_back(cap_data[i]);
        end
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        cap_clear();
        cap_en = 1'b1;
        run_frame();
        check("alone_gap", first_wait, 0);
        wait_drain();
        cap_en = 1'b0;
        check("alone_len", cap_data.size(), 20);
        if (cap_data.size() == 20 && ref_data.size() == 20) begin
            for (int i = 0; i < 20; i++) check("b2b_vs_alone", int'(ref_data[i]), int'(cap_data[i]));
        end

        // Reset three cycles into FLUSH after a 4-sample frame
        stim_q = '{9, 8, 7, 6};
        run_frame();
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        in_frame = 1'b0;
        #1;
        check("midflush_m_valid", int'(m_valid), 0);
        check("midflush_m_last", int'(m_last), 0);
        check("midflush_fir_x", int'(fir_x), 0);
        check("midflush_m_count", int'(m_count), 0);
        check("midflush_busy", int'(busy), 0);
        check("midflush_s_ready", int'(s_ready), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        mv_cnt = 0;
        repeat (30) @(posedge clk);
        #1;
        check("midflush_no_output", mv_cnt, 0);

        // Continuous 3000-sample frame
        stim_q.delete();
        for (int i = 0; i < 3000; i++) stim_q.push_back(((i * 37 + 11) % 256) - 128);
        mv_cnt = 0;
        run_frame();
        wait_drain();
        check("long_outputs", mv_cnt, 3012);

        // Frame long enough for m_count to wrap past 4095
        stim_q.delete();
        for (int i = 0; i < 4100; i++) stim_q.push_back(((i * 53 + 5) % 256) - 128);
        mv_cnt = 0;
        saw_wrap = 1'b0;
        run_frame();
        wait_drain();
        check("wrap_outputs", mv_cnt, 4112);
        check("wrap_seen", int'(saw_wrap), 1);
        check("final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
